// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal operand-width range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full-adder slice used as the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on an
// accepted start, resolves one bit per clock LSB-first through a single
// full-adder slice and carry flip-flop, then presents a registered sum and
// carry-out alongside a one-cycle done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (cout=1 meaning no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_adder: WIDTH out of range 1..64");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_load;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Operand conditioning at capture: subtraction is a + ~b + 1.
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    // Result register after this cycle's bit enters at the MSB; on the last
    // RUN cycle this is the completed LSB-first assembled sum.
    always_comb res_next = (res_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b_load;
                        carry  <= carry_load;
                        cnt    <= '0;
                        res_sr <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= fa_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=4 instance and a WIDTH=1
// instance, each with an expected-result queue filled at stimulus time and
// drained by an independent monitor on every done pulse.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sub = 1'b0;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic         a1 = 1'b0;
    logic         b1 = 1'b0;
    logic         cin1 = 1'b0;
    logic         busy1, done1, cout1;
    logic         sum1;

    int           checks = 0;
    int           fails  = 0;
    logic [7:0]   q4[$];
    logic [7:0]   q1[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: packed {cout, sum} from plain integer arithmetic.
    function automatic logic [7:0] model(input int w, input int unsigned ta, input int unsigned tb_,
                                         input bit tc, input bit ts);
        int unsigned mask = (32'd1 << w) - 1;
        int unsigned s;
        int unsigned c;
        int unsigned tot;
        if (ts) begin
            s = (ta - tb_) & mask;
            c = (ta >= tb_) ? 1 : 0;
        end else begin
            tot = ta + tb_ + 32'(tc);
            s   = tot & mask;
            c   = (tot >> w) & 1;
        end
        return 8'((c << w) | s);
    endfunction

    // Monitors: pop the expected result whenever a done pulse appears.
    always @(negedge clk) begin
        logic [7:0] e;
        check("busy_done_excl4", 64'(busy & done), 64'd0);
        if (done) begin
            if (q4.size() == 0) check("unexpected_done4", 64'd1, 64'd0);
            else begin
                e = q4.pop_front();
                check("result4", 64'({cout, sum}), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        check("busy_done_excl1", 64'(busy1 & done1), 64'd0);
        if (done1) begin
            if (q1.size() == 0) check("unexpected_done1", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                check("result1", 64'({cout1, sum1}), 64'(e));
            end
        end
    end

    // Called at a negedge with dut4 in IDLE; returns at a negedge in IDLE.
    task automatic op4(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        int edges = 0;
        int busy_cnt = 0;
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        q4.push_back(model(W, 32'(ta), 32'(tb_), tc, ts));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        while (edges < 40) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
            if (done) break;
            if (edges < 40) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        check("latency4", 64'(edges), 64'(W + 1));
        check("busy_cycles4", 64'(busy_cnt), 64'(W));
        @(negedge clk);
    endtask

    task automatic op1(input logic ta, input logic tb_, input logic tc);
        int edges = 0;
        a1 = ta; b1 = tb_; cin1 = tc; sub = 1'b0; start1 = 1'b1;
        q1.push_back(model(1, 32'(ta), 32'(tb_), tc, 1'b0));
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1 = ~ta; b1 = ~tb_; cin1 = ~tc;
        while (edges < 20) begin
            @(negedge clk);
            edges++;
            if (done1) break;
        end
        check("latency1", 64'(edges), 64'd2);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_sum1", 64'({cout1, sum1, busy1, done1}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases including carry edges.
        op4(4'h3, 4'h5, 1'b0, 1'b0);
        op4(4'hF, 4'h1, 1'b0, 1'b0);
        op4(4'hF, 4'hF, 1'b1, 1'b0);
        op4(4'h0, 4'h0, 1'b1, 1'b0);

        // Exhaustive WIDTH=4 and WIDTH=1.
        for (int i = 0; i < 512; i++)
            op4(W'(i & 15), W'((i >> 4) & 15), 1'(i >> 8), 1'b0);
        for (int i = 0; i < 8; i++)
            op1(1'(i), 1'(i >> 1), 1'(i >> 2));

        // Random operations.
        for (int i = 0; i < 30; i++)
            op4(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        // Abort mid-run at cnt==2: no result is expected for it.
        op4(4'hA, 4'h7, 1'b1, 1'b0);
        a = 4'hC; b = 4'h3; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        op4(4'h9, 4'h6, 1'b0, 1'b0);

        // Start held high with operands changing every cycle.
        start = 1'b1;
        for (int k = 0; k < 5 * (W + 2); k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
            if (k % (W + 2) == 0) q4.push_back(model(W, 32'(a), 32'(b), cin, 1'b0));
            @(posedge clk);
            @(negedge clk);
            check("held_done", 64'(done), 64'((k % (W + 2)) == W));
        end
        start = 1'b0;
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        op4(4'h5, 4'h7, 1'b0, 1'b1);
        op4(4'h7, 4'h5, 1'b0, 1'b1);
        op4(4'h3, 4'h4, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++)
            op4(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`endif

        repeat (10) @(negedge clk);
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
